// File: rtl/clint_pkg.sv
// Shared encodings for the core-local interruptor: opcodes, CSR addresses, cause codes,
// mstatus bit positions and the trap/return sequencer state type.
package clint_pkg;

    localparam logic [31:0] InstEcall  = 32'h0000_0073;
    localparam logic [31:0] InstEbreak = 32'h0010_0073;
    localparam logic [31:0] InstMret   = 32'h3020_0073;

    localparam logic [11:0] CsrMepc    = 12'h341;
    localparam logic [11:0] CsrMstatus = 12'h300;
    localparam logic [11:0] CsrMcause  = 12'h342;

    localparam logic [31:0] CauseEcallM     = 32'd11;
    localparam logic [31:0] CauseBreakpoint = 32'd3;
    localparam logic [31:0] CauseMTimerInt  = 32'h8000_0007;

    localparam int unsigned MstatusMie   = 3;
    localparam int unsigned MstatusMpie  = 7;
    localparam int unsigned MstatusMppLo = 11;

    localparam logic [1:0] PrivMachine = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StWMepc,
        StWMstatus,
        StWMcause,
        StAssert,
        StWMstatusMret,
        StAssertMret
    } clint_state_e;

    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms, input logic [1:0] priv);
        logic [31:0] r;
        r = ms;
        r[MstatusMppLo+1:MstatusMppLo] = priv;
        r[MstatusMpie]                 = ms[MstatusMie];
        r[MstatusMie]                  = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r = ms;
        r[MstatusMie]  = ms[MstatusMpie];
        r[MstatusMpie] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/clint.sv
// Trap/return sequencer: detects ECALL/EBREAK/MRET and timer interrupts, writes mepc,
// mstatus and mcause one per cycle through the CSR port, then redirects the PC.
module clint
    import clint_pkg::*;
(
    input  logic        sys_clk,
    input  logic        sys_reset,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        int_req_i,
    input  logic [1:0]  privilege_i,
    input  logic [31:0] csr_mtvec_i,
    input  logic [31:0] csr_mepc_i,
    input  logic [31:0] csr_mstatus_i,
    output logic        clint_wr_en_o,
    output logic [31:0] clint_wr_addr_o,
    output logic [31:0] clint_wr_data_o,
    output logic        wr_privilege_en_o,
    output logic [1:0]  wr_privilege_ctrl_o,
    output logic        hold_flag_o,
    output logic        int_assert_o,
    output logic [31:0] int_addr_o
);

    clint_state_e state_q, state_d;
    logic [31:0]  epc_q, epc_d;
    logic [31:0]  cause_q, cause_d;

    logic is_ecall, is_ebreak, is_mret, sync_req, async_req;

    assign is_ecall  = (inst_i == InstEcall);
    assign is_ebreak = (inst_i == InstEbreak);
    assign is_mret   = (inst_i == InstMret);
    assign sync_req  = is_ecall | is_ebreak;
    assign async_req = int_req_i & csr_mstatus_i[MstatusMie] & ~(sync_req | is_mret);

    always_ff @(posedge sys_clk or posedge sys_reset) begin
        if (sys_reset) begin
            state_q <= StIdle;
            epc_q   <= 32'd0;
            cause_q <= 32'd0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        epc_d               = epc_q;
        cause_d             = cause_q;
        clint_wr_en_o       = 1'b0;
        clint_wr_addr_o     = 32'd0;
        clint_wr_data_o     = 32'd0;
        wr_privilege_en_o   = 1'b0;
        wr_privilege_ctrl_o = 2'b00;
        int_assert_o        = 1'b0;
        int_addr_o          = 32'd0;
        hold_flag_o         = 1'b1;

        unique case (state_q)
            StIdle: begin
                // Stall in the detect cycle so the trapping instruction stays frozen in ID/EX.
                hold_flag_o = (sync_req | async_req | is_mret) & ~sys_reset;
                if (sync_req) begin
                    epc_d   = inst_addr_i;
                    cause_d = is_ecall ? CauseEcallM : CauseBreakpoint;
                    state_d = StWMepc;
                end else if (async_req) begin
                    epc_d   = jump_flag_i ? jump_addr_i : inst_addr_i;
                    cause_d = CauseMTimerInt;
                    state_d = StWMepc;
                end else if (is_mret) begin
                    state_d = StWMstatusMret;
                end
            end
            StWMepc: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = {20'd0, CsrMepc};
                clint_wr_data_o = epc_q;
                state_d         = StWMstatus;
            end
            StWMstatus: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = {20'd0, CsrMstatus};
                clint_wr_data_o = trap_mstatus(csr_mstatus_i, privilege_i);
                state_d         = StWMcause;
            end
            StWMcause: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = {20'd0, CsrMcause};
                clint_wr_data_o = cause_q;
                state_d         = StAssert;
            end
            StAssert: begin
                int_assert_o        = 1'b1;
                int_addr_o          = csr_mtvec_i;
                wr_privilege_en_o   = 1'b1;
                wr_privilege_ctrl_o = PrivMachine;
                state_d             = StIdle;
            end
            StWMstatusMret: begin
                clint_wr_en_o   = 1'b1;
                clint_wr_addr_o = {20'd0, CsrMstatus};
                clint_wr_data_o = mret_mstatus(csr_mstatus_i);
                state_d         = StAssertMret;
            end
            StAssertMret: begin
                int_assert_o        = 1'b1;
                int_addr_o          = csr_mepc_i;
                wr_privilege_en_o   = 1'b1;
                wr_privilege_ctrl_o = csr_mstatus_i[MstatusMppLo+1:MstatusMppLo];
                state_d             = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: doc/clint.md
# clint

Core Local Interruptor: the trap/return sequencer that drives the CSR file's `clint_*` write port. It detects ECALL, EBREAK and MRET instructions in the decode stage, and accepts a pending machine-timer interrupt. It then stalls the pipeline and writes `mepc`, `mstatus` and `mcause` one per cycle. Finally it redirects the PC to `mtvec` (trap) or `mepc` (return) and updates privilege mode. It sits between ID/EX, the CSR file and the PC/control unit.

## Interface
Parameters:
- none. Encodings and addresses come from `cpu_define.v`.

Ports:
- `sys_clk`  in  1  clock
- `sys_reset`  in  1  asynchronous, active-high reset
- `inst_i`  in  32  instruction currently in ID/EX
- `inst_addr_i`  in  32  PC of `inst_i`
- `jump_flag_i`  in  1  EX is redirecting this cycle
- `jump_addr_i`  in  32  EX redirect target
- `int_req_i`  in  1  machine timer interrupt request, level
- `privilege_i`  in  2  current privilege (CSR file `privilege_o`)
- `csr_mtvec_i`, `csr_mepc_i`, `csr_mstatus_i`  in  32 each  direct CSR taps
- `clint_wr_en_o`  out  1  CSR write strobe
- `clint_wr_addr_o`  out  32  CSR address, zero-extended 12-bit
- `clint_wr_data_o`  out  32  CSR write data
- `wr_privilege_en_o`  out  1  privilege write strobe
- `wr_privilege_ctrl_o`  out  2  new privilege
- `hold_flag_o`  out  1  pipeline stall request
- `int_assert_o`  out  1  PC redirect strobe
- `int_addr_o`  out  32  PC redirect target

## Operation
- Opcodes are decoded as exact 32-bit matches:
  - ECALL = 0x00000073
  - EBREAK = 0x00100073
  - MRET = 0x30200073
- FSM states: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, ASSERT, W_MSTATUS_MRET, ASSERT_MRET.
- IDLE resolves requests in this priority order:
  1. **Sync trap (ECALL/EBREAK):** latch `epc` = `inst_addr_i`. Latch `cause` = 11 for ECALL, 3 for EBREAK. Go to W_MEPC.
  2. **Async trap:** taken when `int_req_i`=1, `csr_mstatus_i[3]` (MIE)=1, and `inst_i` is not ECALL, EBREAK or MRET. Latch `epc` = `jump_flag_i` ? `jump_addr_i` : `inst_addr_i`. Latch `cause` = 0x80000007. Go to W_MEPC.
  3. **MRET:** go to W_MSTATUS_MRET.
- CSR writes (`clint_wr_en_o`=1 in each of these states, otherwise 0):
  - W_MEPC → W_MSTATUS: addr 0x341, data `epc`.
  - W_MSTATUS → W_MCAUSE: addr 0x300, data = `csr_mstatus_i` with these changes:
    - MPP[12:11] ← `privilege_i`
    - MPIE[7] ← MIE[3]
    - MIE[3] ← 0
    - all other bits unchanged
  - W_MCAUSE → ASSERT: addr 0x342, data `cause`.
  - W_MSTATUS_MRET → ASSERT_MRET: addr 0x300, data = `csr_mstatus_i` with these changes:
    - MIE[3] ← MPIE[7]
    - MPIE[7] ← 1
    - MPP unchanged (machine/supervisor only; no clearing)
- Redirect states:
  - ASSERT: `int_assert_o`=1, `int_addr_o`=`csr_mtvec_i`, `wr_privilege_en_o`=1, `wr_privilege_ctrl_o`=2'b11. Go to IDLE.
  - ASSERT_MRET: `int_assert_o`=1, `int_addr_o`=`csr_mepc_i`, `wr_privilege_en_o`=1, `wr_privilege_ctrl_o`=`csr_mstatus_i[12:11]`. Go to IDLE.
- `int_req_i` is ignored outside IDLE. No nesting and no queueing; a still-asserted request is re-evaluated in IDLE against the new MIE.
- Integration requirement: the CSR file gives CSR-instruction writes priority over this port. The control unit must use `hold_flag_o` to suppress CSR-instruction writes while the FSM is non-IDLE.

## Timing
- Reset value of every output is 0. On reset: state = IDLE, `epc` = 0, `cause` = 0.
- Reset asserted mid-sequence aborts immediately. Writes already committed stay committed; no further writes occur.
- `hold_flag_o` = (state != IDLE) | (IDLE & any request accepted). It is combinational in the detect cycle T so the trapping instruction is frozen.
- Trap sequence: T detect, T+1 mepc, T+2 mstatus, T+3 mcause, T+4 redirect; hold high T..T+4; IDLE at T+5.
- MRET sequence: T detect, T+1 mstatus, T+2 redirect; hold high T..T+2.
- All outputs other than `hold_flag_o` are decoded from registered state and latched `epc`/`cause` (Moore).
- Because mstatus is written at T+2 from the live tap, the CSR file's write-through makes the T+1 mepc write visible at `csr_mepc_i` for a following MRET.

## Structure
- `cpu_define.v` holds: ECALL/EBREAK/MRET encodings, CSR addresses (existing `CSR_*`), mcause codes (`CAUSE_ECALL_M`, `CAUSE_BREAKPOINT`, `CAUSE_M_TIMER_INT`), mstatus bit positions, privilege encodings (existing `PRIVILEG_*`).
- State encodings are local `localparam`s.
- No sub-module is needed; it is a single flat FSM.

## Test plan
- **ECALL:** ECALL at 0x100, mtvec=0x200, mstatus=0x8, privilege=11 → writes 0x341←0x100, 0x300←0x1880, 0x342←11 at T+1..T+3; redirect to 0x200 with privilege 11 at T+4; hold T..T+4.
- **Timer interrupt:** with mstatus=0x0 → no action, hold 0. With mstatus=0x8, inst_addr=0x40, jump_flag=1, jump_addr=0x80 → mepc←0x80, mcause←0x80000007.
- **MRET:** mepc=0x104, mstatus=0x1880 → 0x300←0x1888 at T+1; redirect to 0x104 with privilege 11 at T+2; hold T..T+2.
- **Simultaneous events:** EBREAK and `int_req_i`=1 with MIE=1 in the same cycle → only the sync trap is taken, mcause=3. The interrupt stays pending and is ignored afterwards because MIE=0.
- **Reset mid-sequence:** reset asserted in W_MSTATUS → all outputs 0 the next cycle; no mcause write; IDLE after release.
- **Held interrupt:** `int_req_i` held high across a full trap sequence → exactly one sequence. A second trap occurs only after software writes MIE=1.
